// File: rtl/pr_pkg.sv
// Shared types for the differential alert channel: sender/receiver pairs,
// receiver FSM states and the idle (reset) encodings of both directions.
package pr_pkg;

  typedef struct packed {
    logic alert_p;
    logic alert_n;
  } alert_tx_t;

  typedef struct packed {
    logic ping_p;
    logic ping_n;
    logic ack_p;
    logic ack_n;
  } alert_rx_t;

  typedef enum logic [1:0] {
    AlertRxIdle,
    AlertRxAckHold,
    AlertRxPause0,
    AlertRxPause1
  } alert_rx_state_e;

  localparam alert_tx_t ALERT_TX_IDLE = '{alert_p: 1'b0, alert_n: 1'b1};
  localparam alert_rx_t ALERT_RX_IDLE = '{ping_p: 1'b0, ping_n: 1'b1,
                                         ack_p:  1'b0, ack_n:  1'b1};

endpackage

// File: rtl/alert_rx_chan.sv
// One alert receiver channel: 2-flop synchronizer, integrity check, ack FSM.
// Ping support is compiled in only when PR_ALERT_PING_EN is defined.
module alert_rx_chan
  import pr_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  alert_tx_t alert_tx_i,
  output alert_rx_t alert_rx_o,
  output logic      alert_o,
  output logic      integ_fail_o,
  input  logic      ping_req_i,
  output logic      ping_ok_o
);

  logic [1:0] sync_p_d, sync_p_q;
  logic [1:0] sync_n_d, sync_n_q;
  logic       pair_bad_d, pair_bad_q;
  logic       integ_fail_d, integ_fail_q;
  logic       ack_d, ack_q;
  logic       alert_d, alert_q;
  logic       accept;
  logic       alert_asserted, alert_deasserted;
  alert_rx_state_e state_d, state_q;

  assign alert_asserted   =  sync_p_q[1] & ~sync_n_q[1];
  assign alert_deasserted = ~sync_p_q[1] &  sync_n_q[1];

  // A single non-complementary cycle is sender skew; two in a row is a fault.
  always_comb begin
    sync_p_d     = {sync_p_q[0], alert_tx_i.alert_p};
    sync_n_d     = {sync_n_q[0], alert_tx_i.alert_n};
    pair_bad_d   = (sync_p_q[1] == sync_n_q[1]);
    integ_fail_d = pair_bad_d & pair_bad_q;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    accept  = 1'b0;
    if (integ_fail_d) begin
      state_d = AlertRxIdle;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        AlertRxIdle: begin
          if (alert_asserted) begin
            state_d = AlertRxAckHold;
            ack_d   = 1'b1;
            accept  = 1'b1;
          end
        end
        AlertRxAckHold: begin
          if (alert_deasserted) begin
            state_d = AlertRxPause0;
            ack_d   = 1'b0;
          end
        end
        AlertRxPause0: state_d = AlertRxPause1;
        AlertRxPause1: state_d = AlertRxIdle;
        default:       state_d = AlertRxIdle;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the synchronizer
  // resets to the deasserted encoding so reset never looks like an alert.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p_q     <= {2{ALERT_TX_IDLE.alert_p}};
      sync_n_q     <= {2{ALERT_TX_IDLE.alert_n}};
      pair_bad_q   <= 1'b0;
      integ_fail_q <= 1'b0;
      ack_q        <= 1'b0;
      alert_q      <= 1'b0;
      state_q      <= AlertRxIdle;
    end else begin
      sync_p_q     <= sync_p_d;
      sync_n_q     <= sync_n_d;
      pair_bad_q   <= pair_bad_d;
      integ_fail_q <= integ_fail_d;
      ack_q        <= ack_d;
      alert_q      <= alert_d;
      state_q      <= state_d;
    end
  end

`ifdef PR_ALERT_PING_EN
  logic ping_level_d, ping_level_q;
  logic ping_pending_d, ping_pending_q;
  logic ping_ok_d, ping_ok_q;

  // The handshake that follows a ping is its answer, not a real alert.
  always_comb begin
    ping_level_d   = ping_level_q;
    ping_pending_d = ping_pending_q;
    ping_ok_d      = accept &  ping_pending_q;
    alert_d        = accept & ~ping_pending_q;
    if (accept && ping_pending_q) begin
      ping_pending_d = 1'b0;
    end
    if (state_q == AlertRxIdle && ping_req_i && !ping_pending_q) begin
      ping_level_d   = ~ping_level_q;
      ping_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ping_level_q   <= ALERT_RX_IDLE.ping_p;
      ping_pending_q <= 1'b0;
      ping_ok_q      <= 1'b0;
    end else begin
      ping_level_q   <= ping_level_d;
      ping_pending_q <= ping_pending_d;
      ping_ok_q      <= ping_ok_d;
    end
  end

  assign alert_rx_o.ping_p = ping_level_q;
  assign alert_rx_o.ping_n = ~ping_level_q;
  assign ping_ok_o         = ping_ok_q;
`else
  logic unused_ping_req;
  assign unused_ping_req   = ping_req_i;
  assign alert_d           = accept;
  assign alert_rx_o.ping_p = ALERT_RX_IDLE.ping_p;
  assign alert_rx_o.ping_n = ALERT_RX_IDLE.ping_n;
  assign ping_ok_o         = 1'b0;
`endif

  assign alert_rx_o.ack_p = ack_q;
  assign alert_rx_o.ack_n = ~ack_q;
  assign alert_o          = alert_q;
  assign integ_fail_o     = integ_fail_q;

endmodule

// File: rtl/alert_rx_bank.sv
// Bank of independent alert receivers, one alert_rx_chan per channel.
// Ping support follows PR_ALERT_PING_EN inside alert_rx_chan.
module alert_rx_bank
  import pr_pkg::*;
#(
  parameter int NumAlerts = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  alert_tx_t [NumAlerts-1:0] alert_tx_i,
  output alert_rx_t [NumAlerts-1:0] alert_rx_o,
  output logic      [NumAlerts-1:0] alert_o,
  output logic      [NumAlerts-1:0] integ_fail_o,
  input  logic      [NumAlerts-1:0] ping_req_i,
  output logic      [NumAlerts-1:0] ping_ok_o
);

  for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
    alert_rx_chan u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .alert_tx_i   (alert_tx_i[i]),
      .alert_rx_o   (alert_rx_o[i]),
      .alert_o      (alert_o[i]),
      .integ_fail_o (integ_fail_o[i]),
      .ping_req_i   (ping_req_i[i]),
      .ping_ok_o    (ping_ok_o[i])
    );
  end

endmodule

// File: tb/tb_alert_rx_bank.sv
// Scoreboard bench for alert_rx_bank: senders push the expected pulse cycle,
// a negedge monitor pops and compares whenever alert_o/ping_ok_o fires.
module tb_alert_rx_bank;
  import pr_pkg::*;

  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  alert_tx_t [N-1:0] alert_tx;
  alert_rx_t [N-1:0] alert_rx;
  logic      [N-1:0] alert_o, integ_fail, ping_req, ping_ok;

  alert_rx_bank #(.NumAlerts(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .alert_tx_i   (alert_tx),
    .alert_rx_o   (alert_rx),
    .alert_o      (alert_o),
    .integ_fail_o (integ_fail),
    .ping_req_i   (ping_req),
    .ping_ok_o    (ping_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit ping;
  } exp_t;

  exp_t exp_q[N][$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tx(input int c, input bit p, input bit n);
    alert_tx[c].alert_p = p;
    alert_tx[c].alert_n = n;
  endtask

  // Expected pulse: input driven at negedge 'now' is sampled on the next edge,
  // so the registered pulse shows up three edges later.
  task automatic push(input int c, input int at, input bit ping);
    exp_t e;
    e.cyc  = at;
    e.ping = ping;
    exp_q[c].push_back(e);
  endtask

  task automatic assert_alert(input int c, input bit ping);
    set_tx(c, 1'b1, 1'b0);
    push(c, cyc + 3, ping);
  endtask

  task automatic wait_ack(input int c, input bit val);
    int n = 0;
    while (alert_rx[c].ack_p !== val && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ch%0d_ack_wait", c), int'(alert_rx[c].ack_p), int'(val));
  endtask

  // Sender model: a well-behaved peer doing full handshakes with random gaps.
  task automatic sender(input int c, input int n_hs);
    repeat (n_hs) begin
      tick($urandom_range(0, 4));
      assert_alert(c, 1'b0);
      wait_ack(c, 1'b1);
      tick($urandom_range(0, 4));
      set_tx(c, 1'b0, 1'b1);
      wait_ack(c, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < N; c++) begin
      if (alert_o[c] === 1'b1 || ping_ok[c] === 1'b1) begin
        if (exp_q[c].size() == 0) begin
          check($sformatf("ch%0d_unexpected_pulse", c), exp_q[c].size(), 1);
        end else begin
          e = exp_q[c].pop_front();
          check($sformatf("ch%0d_pulse_cycle", c), cyc, e.cyc);
          check($sformatf("ch%0d_alert_kind", c), int'(alert_o[c]), int'(!e.ping));
          check($sformatf("ch%0d_ping_ok_kind", c), int'(ping_ok[c]), int'(e.ping));
          check($sformatf("ch%0d_ack_at_pulse", c),
                int'({alert_rx[c].ack_p, alert_rx[c].ack_n}), 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int d;
    int seen;
    rst_n    = 1'b0;
    ping_req = '0;
    for (int c = 0; c < N; c++) set_tx(c, 1'b0, 1'b1);
    tick(3);
    check("rst_alert_o", int'(alert_o), 0);
    check("rst_integ", int'(integ_fail), 0);
    check("rst_ping_ok", int'(ping_ok), 0);
    for (int c = 0; c < N; c++)
      check($sformatf("rst_rx%0d", c), int'(alert_rx[c]), 4'b0101);
    rst_n = 1'b1;
    tick(3);

    // Basic handshake on ch1, then a re-assert after only one deasserted cycle.
    assert_alert(1, 1'b0);
    tick(2); check("basic_pre", int'(alert_o), 0);
    tick(1); check("basic_pulse", int'(alert_o), 3'b010);
    check("basic_ack", int'({alert_rx[1].ack_p, alert_rx[1].ack_n}), 2);
    tick(1); check("basic_width", int'(alert_o), 0);
    tick(2);
    set_tx(1, 1'b0, 1'b1); d = cyc;
    tick(1);
    set_tx(1, 1'b1, 1'b0); push(1, d + 6, 1'b0);
    tick(1); check("release_hold", int'(alert_rx[1].ack_p), 1);
    tick(1); check("release_drop", int'({alert_rx[1].ack_p, alert_rx[1].ack_n}), 1);
    tick(2); check("pause_blocks", int'(alert_o[1]), 0);
    tick(1); check("pause_accept", int'(alert_o[1]), 1);
    set_tx(1, 1'b0, 1'b1);
    wait_ack(1, 1'b0);
    tick(3);

    // Integrity: ch0 held at p=n=1 for four sampled cycles.
    set_tx(0, 1'b1, 1'b1);
    tick(3); check("integ_one_cycle_ok", int'(integ_fail[0]), 0);
    tick(1); check("integ_set", int'(integ_fail[0]), 1);
    set_tx(0, 1'b0, 1'b1);
    tick(2); check("integ_still", int'(integ_fail[0]), 1);
    check("integ_ack", int'({alert_rx[0].ack_p, alert_rx[0].ack_n}), 1);
    tick(1); check("integ_clear", int'(integ_fail[0]), 0);
    tick(3);

    // Skew: p leads n by one cycle on ch2.
    seen = 0;
    set_tx(2, 1'b1, 1'b1);
    tick(1);
    assert_alert(2, 1'b0);
    repeat (6) begin
      tick(1);
      seen |= int'(integ_fail[2]);
    end
    check("skew_no_integ", seen, 0);
    set_tx(2, 1'b0, 1'b0);
    tick(1);
    set_tx(2, 1'b0, 1'b1);
    wait_ack(2, 1'b0);
    tick(3);

    // Simultaneous alerts on all channels.
    for (int c = 0; c < N; c++) assert_alert(c, 1'b0);
    tick(3); check("simul_pulse", int'(alert_o), 3'b111);
    for (int c = 0; c < N; c++)
      check($sformatf("simul_ack%0d", c), int'(alert_rx[c].ack_p), 1);
    for (int c = 0; c < N; c++) set_tx(c, 1'b0, 1'b1);
    for (int c = 0; c < N; c++) wait_ack(c, 1'b0);
    tick(3);

    // Randomized independent senders.
    fork
      sender(0, 8);
      sender(1, 8);
      sender(2, 8);
    join
    tick(4);

`ifdef PR_ALERT_PING_EN
    ping_req[0] = 1'b1;
    tick(1);
    check("ping_toggle", int'({alert_rx[0].ping_p, alert_rx[0].ping_n}), 2);
    assert_alert(0, 1'b1);
    wait_ack(0, 1'b1);
    ping_req[0] = 1'b0;
    set_tx(0, 1'b0, 1'b1);
    wait_ack(0, 1'b0);
    tick(4);
    check("ping_no_retoggle", int'({alert_rx[0].ping_p, alert_rx[0].ping_n}), 2);
`endif

    // Reset while ch0 is in AckHold, alert kept asserted through reset.
    assert_alert(0, 1'b0);
    wait_ack(0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_ack", int'({alert_rx[0].ack_p, alert_rx[0].ack_n}), 1);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, cyc + 3, 1'b0);
    wait_ack(0, 1'b1);
    set_tx(0, 1'b0, 1'b1);
    wait_ack(0, 1'b0);
    tick(4);

    for (int c = 0; c < N; c++)
      check($sformatf("ch%0d_drain", c), exp_q[c].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
